// File: rtl/fetch_control_unit_if.sv
// Fetch-control bundle: start/stall/branch/halt in, fetch address, flushes and status out.
// Latency: none, plain wires between the sequencer and its neighbours.
// Backpressure: stall from hazard logic; no ready/valid handshake inside the bundle.
interface fetch_control_unit_if;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt_req;
  logic [31:0] pc_out;
  logic [31:0] pc_plus1;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        running;
  logic        halted;
  logic [31:0] cycle_count;
  logic [31:0] fetch_count;

  // Pipeline side: drives the requests, observes the fetch controls.
  modport master (
    output start, stall, branch_taken, branch_target, halt_req,
    input  pc_out, pc_plus1, fetch_valid, flush_if_id, flush_id_ex,
           running, halted, cycle_count, fetch_count
  );

  // Sequencer side.
  modport slave (
    input  start, stall, branch_taken, branch_target, halt_req,
    output pc_out, pc_plus1, fetch_valid, flush_if_id, flush_id_ex,
           running, halted, cycle_count, fetch_count
  );
endinterface

// File: rtl/fetch_control_unit.sv
// Fetch sequencer: owns the PC, start/halt run control, branch redirect and flushes.
// Latency: outputs combinational from state; PC/state update at the next rising edge.
// Backpressure: stall holds PC and fetch count; branch_taken overrides stall and halt.
module fetch_control_unit #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter logic [31:0] PC_LIMIT     = 32'd1024,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_control_unit_if.slave  fc
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [31:0]     fcnt_q, fcnt_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            s1_q, s2_q, s3_q;
  logic            start_pulse;
  logic            active;
  logic            at_limit;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Two-flop synchronizer for the raw switch plus one flop of history for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= fc.start;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign start_pulse = s2_q & ~s3_q;
  assign active      = (state_q == RUN) || (state_q == DRAIN);
  assign at_limit    = (pc_q >= PC_LIMIT);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: branch redirect beats stall, stall beats halt/limit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_pulse) state_d = RUN;
      RUN: begin
        if (fc.branch_taken)                  state_d = RUN;
        else if (fc.stall)                    state_d = RUN;
        else if (fc.halt_req || at_limit)     state_d = DRAIN;
      end
      DRAIN: begin
        if (fc.branch_taken)                  state_d = RUN;
        else if (drain_q == '0)               state_d = HALTED;
      end
      HALTED:  if (start_pulse) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // PC, counters and drain countdown next values.
  always_comb begin
    pc_d    = pc_q;
    fcnt_d  = fcnt_q;
    drain_d = drain_q;
    cyc_d   = active ? sat_inc(cyc_q) : cyc_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (start_pulse) begin
          pc_d   = RESET_PC;
          cyc_d  = 32'd0;
          fcnt_d = 32'd0;
        end
      end
      RUN: begin
        if (fc.branch_taken) begin
          pc_d = fc.branch_target;
        end else if (fc.stall) begin
          pc_d = pc_q;
        end else if (fc.halt_req || at_limit) begin
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else begin
          pc_d   = pc_q + 32'd1;
          fcnt_d = sat_inc(fcnt_q);
        end
      end
      DRAIN: begin
        if (fc.branch_taken)     pc_d = fc.branch_target;
        else if (drain_q != '0)  drain_d = drain_q - 1'b1;
      end
      default: pc_d = pc_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      cyc_q   <= 32'd0;
      fcnt_q  <= 32'd0;
      drain_q <= '0;
    end else begin
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      fcnt_q  <= fcnt_d;
      drain_q <= drain_d;
    end
  end

  // Outputs: fetch qualifier and flushes are gated by state so IDLE/HALTED stay quiet.
  always_comb begin
    fc.pc_out      = pc_q;
    fc.pc_plus1    = pc_q + 32'd1;
    fc.fetch_valid = (state_q == RUN) && !at_limit;
    fc.flush_if_id = active && fc.branch_taken;
    fc.flush_id_ex = active && fc.branch_taken;
    fc.running     = active;
    fc.halted      = (state_q == HALTED);
    fc.cycle_count = cyc_q;
    fc.fetch_count = fcnt_q;
  end

endmodule

// File: tb/tb_fetch_control_unit.sv
module tb_fetch_control_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_control_unit_if ifa ();
  fetch_control_unit_if ifb ();

  fetch_control_unit u_main (.clk(clk), .rst(rst), .fc(ifa));
  fetch_control_unit #(.PC_LIMIT(32'd8)) u_lim (.clk(clk), .rst(rst), .fc(ifb));

  // Reference model: one program-run tracker per DUT instance.
  typedef enum {P_OFF, P_FETCHING, P_DRAINING, P_STOPPED} phase_e;
  phase_e      mph   [2];
  logic [31:0] mpc   [2];
  logic [31:0] mcyc  [2];
  logic [31:0] mfc   [2];
  int          mspent[2];
  logic [31:0] mlim  [2];
  logic        samp  [3];   // start as seen at the last three edges, [0] newest

  logic        cur_start, cur_stall, cur_bt, cur_hr;
  logic [31:0] cur_tgt;

  logic [31:0] snap_pc0;
  logic [31:0] snap_fc0;
  logic [31:0] snap_cc0;
  logic        snap_fv0, snap_h0, snap_fl0;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [31:0] sinc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mph[k] = P_OFF; mpc[k] = 32'd0; mcyc[k] = 32'd0; mfc[k] = 32'd0; mspent[k] = 0;
    end
    for (int j = 0; j < 3; j++) samp[j] = 1'b0;
  endtask

  task automatic model_step();
    logic pulse;
    pulse = samp[1] & ~samp[2];
    for (int k = 0; k < 2; k++) begin
      case (mph[k])
        P_OFF, P_STOPPED: if (pulse) begin
          mph[k] = P_FETCHING; mpc[k] = 32'd0; mcyc[k] = 32'd0; mfc[k] = 32'd0;
        end
        P_FETCHING: begin
          mcyc[k] = sinc(mcyc[k]);
          if (cur_bt) mpc[k] = cur_tgt;
          else if (cur_stall) ;
          else if (cur_hr || mpc[k] >= mlim[k]) begin
            mph[k] = P_DRAINING; mspent[k] = 0;
          end else begin
            mpc[k] = mpc[k] + 32'd1; mfc[k] = sinc(mfc[k]);
          end
        end
        P_DRAINING: begin
          mcyc[k] = sinc(mcyc[k]);
          if (cur_bt) begin
            mpc[k] = cur_tgt; mph[k] = P_FETCHING;
          end else begin
            mspent[k]++;
            if (mspent[k] == 4) mph[k] = P_STOPPED;
          end
        end
        default: ;
      endcase
    end
    samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = cur_start;
  endtask

  task automatic check_dut(input int k, input logic [31:0] pc, input logic [31:0] pp1,
                           input logic fv, input logic fi, input logic fe, input logic rn,
                           input logic hl, input logic [31:0] cc, input logic [31:0] fcn);
    logic act;
    act = (mph[k] == P_FETCHING) || (mph[k] == P_DRAINING);
    chk($sformatf("u%0d.pc_out", k), pc, mpc[k]);
    chk($sformatf("u%0d.pc_plus1", k), pp1, mpc[k] + 32'd1);
    chk($sformatf("u%0d.fetch_valid", k), {31'd0, fv},
        {31'd0, (mph[k] == P_FETCHING) && (mpc[k] < mlim[k])});
    chk($sformatf("u%0d.flush_if_id", k), {31'd0, fi}, {31'd0, act && cur_bt});
    chk($sformatf("u%0d.flush_id_ex", k), {31'd0, fe}, {31'd0, act && cur_bt});
    chk($sformatf("u%0d.running", k), {31'd0, rn}, {31'd0, act});
    chk($sformatf("u%0d.halted", k), {31'd0, hl}, {31'd0, mph[k] == P_STOPPED});
    chk($sformatf("u%0d.cycle_count", k), cc, mcyc[k]);
    chk($sformatf("u%0d.fetch_count", k), fcn, mfc[k]);
  endtask

  task automatic check_both();
    check_dut(0, ifa.pc_out, ifa.pc_plus1, ifa.fetch_valid, ifa.flush_if_id, ifa.flush_id_ex,
              ifa.running, ifa.halted, ifa.cycle_count, ifa.fetch_count);
    check_dut(1, ifb.pc_out, ifb.pc_plus1, ifb.fetch_valid, ifb.flush_if_id, ifb.flush_id_ex,
              ifb.running, ifb.halted, ifb.cycle_count, ifb.fetch_count);
    snap_pc0 = ifa.pc_out;   snap_fc0 = ifa.fetch_count; snap_cc0 = ifa.cycle_count;
    snap_fv0 = ifa.fetch_valid; snap_h0 = ifa.halted;    snap_fl0 = ifa.flush_if_id;
  endtask

  task automatic drive(input logic st, input logic sl, input logic bt,
                       input logic [31:0] tg, input logic hr);
    cur_start = st; cur_stall = sl; cur_bt = bt; cur_tgt = tg; cur_hr = hr;
    ifa.start = st; ifa.stall = sl; ifa.branch_taken = bt; ifa.branch_target = tg; ifa.halt_req = hr;
    ifb.start = st; ifb.stall = sl; ifb.branch_taken = bt; ifb.branch_target = tg; ifb.halt_req = hr;
  endtask

  task automatic tick(input logic st, input logic sl, input logic bt,
                      input logic [31:0] tg, input logic hr);
    @(negedge clk);
    drive(st, sl, bt, tg, hr);
    #1;
    check_both();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    model_reset();
    #1;
    check_both();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int first_i;
    int guard;
    logic rs;
    mlim[0] = 32'd1024;
    mlim[1] = 32'd8;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    model_reset();
    #2;
    check_both();
    do_reset();

    // Held start switch: one pulse, first fetch three edges after the rise.
    first_i = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      if (first_i < 0 && snap_fv0) first_i = i;
      if (i == 8) begin
        chk("five_cycles_pc", snap_pc0, 32'd5);
        chk("five_cycles_fetch_count", snap_fc0, 32'd5);
        chk("five_cycles_cycle_count", snap_cc0, 32'd5);
      end
    end
    chk("first_fetch_edge", first_i, 32'd3);

    // Branch with simultaneous stall and halt: branch wins.
    tick(1'b0, 1'b0, 1'b1, 32'd6, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 32'h20, 1'b1);
    chk("branch_flush", {31'd0, snap_fl0}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("branch_redirect_pc", snap_pc0, 32'h20);

    // Stall masks halt; halt honoured when stall drops, halted after four drain cycles.
    tick(1'b0, 1'b0, 1'b1, 32'd9, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("stall_hold_pc", snap_pc0, 32'd9);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    first_i = -1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      if (first_i < 0 && snap_h0) first_i = i;
    end
    chk("halt_after_drain", first_i, 32'd4);

    // Restart from HALTED, run the small-limit instance into its limit, branch out of DRAIN.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    guard = 0;
    while (!(mph[1] == P_FETCHING && mpc[1] == 32'd8) && guard < 40) begin
      tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      guard++;
    end
    chk("reach_limit_in_budget", {31'd0, guard < 40}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 32'd3, 1'b0);
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Randomized traffic against the model.
    rs = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        sl, bt, hr;
      logic [31:0] tg;
      if ($urandom_range(0, 19) == 0) rs = ~rs;
      sl = ($urandom_range(0, 9) < 3);
      bt = ($urandom_range(0, 9) == 0);
      hr = ($urandom_range(0, 19) == 0);
      tg = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2000)) : 32'($urandom_range(0, 12));
      tick(rs, sl, bt, tg, hr);
    end

    // Reset in the middle of RUN with a branch pending: no flush, back to IDLE values.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("pre_reset_running", {31'd0, mph[0] == P_FETCHING}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'd5, 1'b0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_both();
    chk("reset_no_flush", {31'd0, snap_fl0}, 32'd0);
    chk("reset_pc", snap_pc0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
